// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared definitions for the nibble-serial adder controller:
//                nibble width, FSM state encoding and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Width of the shared datapath adder.
    localparam int NIBBLE_W = 4;

    // Controller states with fixed encodings.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit so that a
    // single-nibble configuration still has a legal counter.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_4bit
//  Description : 4-bit ripple-carry adder, purely combinational.
//  Ports       : a, b   - 4-bit operands
//                c_in   - carry into bit 0
//                s      - 4-bit sum
//                c_out  - carry out of bit 3
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic       c_out,
    output logic [3:0] s
);

    logic [4:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[4];

endmodule : adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_ctrl
//  Description : Computes a WIDTH-bit a+b+c_in on one shared 4-bit adder,
//                one nibble per clock, least-significant nibble first.
//                Operands arrive on a valid/ready handshake; sum, carry-out
//                and signed overflow leave on a valid/ready handshake.
//  Ports       : clk, rst            - clock, async active-high reset
//                in_valid/in_ready   - operand handshake (ready only in IDLE)
//                a, b, c_in          - operands, sampled on the accept edge
//                out_valid/out_ready - result handshake (valid only in DONE)
//                sum, c_out, ovf     - result, carry-out, signed overflow
//                busy                - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NIB - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;

    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic [WIDTH-1:0]    w_a_next;
    logic [WIDTH-1:0]    w_b_next;
    logic [WIDTH-1:0]    w_sum_next;
    logic [WIDTH-1:0]    w_nib_ins;

    // Shared datapath: the only adder in the block.
    adder_4bit u_adder (
        .a     (r_a_sh[NIBBLE_W-1:0]),
        .b     (r_b_sh[NIBBLE_W-1:0]),
        .c_in  (r_carry),
        .c_out (w_nib_cout),
        .s     (w_nib_sum)
    );

    assign w_a_next   = r_a_sh >> NIBBLE_W;
    assign w_b_next   = r_b_sh >> NIBBLE_W;
    // New nibble enters at the top so that after NIB shifts the first
    // (least-significant) nibble has walked down to bits [3:0]. Built with
    // shifts so the expression stays legal when WIDTH equals one nibble.
    assign w_nib_ins  = WIDTH'(w_nib_sum) << (WIDTH - NIBBLE_W);
    assign w_sum_next = (r_sum_sh >> NIBBLE_W) | w_nib_ins;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= c_in;
                        r_idx    <= '0;
                        r_sum_sh <= '0;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_ovf    <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= w_a_next;
                    r_b_sh   <= w_b_next;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_nib_cout;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        // Final nibble: its bit 3 is the result MSB, so the
                        // overflow flag can be registered on this same edge.
                        r_ovf   <= (r_a_msb == r_b_msb) && (w_nib_sum[NIBBLE_W-1] != r_a_msb);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are decoded from state only; result outputs come
    // straight from flops.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum_sh;
    assign c_out     = r_carry;
    assign ovf       = r_ovf;

endmodule : nibble_serial_adder_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder_ctrl
//  Description : Self-checking bench for nibble_serial_adder_ctrl, WIDTH=16.
//                Expected results come from plain wide arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction. Called #1 after a rising edge.
    // stall  : cycles out_ready stays low while out_valid is high
    // garble : drive junk operands with in_valid=1 during RUN/DONE
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input int stall, input bit garble,
                          input string name);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] e_sum;
        logic             e_cout;
        logic             e_ovf;
        int               k;

        full   = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        e_sum  = full[WIDTH-1:0];
        e_cout = full[WIDTH];
        e_ovf  = (av[WIDTH-1] == bv[WIDTH-1]) && (e_sum[WIDTH-1] != av[WIDTH-1]);

        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s wait_ready: in_ready=%b expected 1 within 20 cycles", name, in_ready);
        end

        in_valid = 1'b1; a = av; b = bv; c_in = cv;
        @(posedge clk); #1;
        if (garble) begin
            a = '1; b = '1; c_in = 1'b1;
        end else begin
            in_valid = 1'b0;
            a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
        end

        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s after_accept: busy=%b in_ready=%b out_valid=%b expected 1 0 0",
                     name, busy, in_ready, out_valid);
        end

        for (int i = 1; i <= NIB; i++) begin
            out_ready = 1'($urandom);   // ignored outside DONE
            @(posedge clk); #1;
            if (i < NIB) begin
                n_checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s run_cycle%0d: out_valid=%b in_ready=%b expected 0 0",
                             name, i, out_valid, in_ready);
                end
            end
        end

        n_checks++;
        if (out_valid !== 1'b1 || sum !== e_sum || c_out !== e_cout || ovf !== e_ovf) begin
            n_errors++;
            $display("FAIL %s result: out_valid=%b sum=%h c_out=%b ovf=%b expected 1 %h %b %b",
                     name, out_valid, sum, c_out, ovf, e_sum, e_cout, e_ovf);
        end

        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || sum !== e_sum || c_out !== e_cout || ovf !== e_ovf
                || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s stall%0d: out_valid=%b sum=%h c_out=%b ovf=%b in_ready=%b expected 1 %h %b %b 0",
                         name, s, out_valid, sum, c_out, ovf, in_ready, e_sum, e_cout, e_ovf);
            end
        end

        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== e_sum
            || c_out !== e_cout || ovf !== e_ovf) begin
            n_errors++;
            $display("FAIL %s after_exit: out_valid=%b in_ready=%b busy=%b sum=%h c_out=%b ovf=%b expected 0 1 0 %h %b %b",
                     name, out_valid, in_ready, busy, sum, c_out, ovf, e_sum, e_cout, e_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0
            || c_out !== 1'b0 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b sum=%h c_out=%b ovf=%b expected 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, c_out, ovf);
        end
        in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "wrap");
        run_op(16'hFFFF, 16'h0001, 1'b1, 1, 1'b0, "wrap_cin");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "pos_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 2, 1'b0, "neg_ovf");
    endtask

    task automatic test_backpressure();
        run_op(16'h00FF, 16'h0001, 1'b0, 6, 1'b0, "backpressure");
        run_op(16'h0F0F, 16'hF0F1, 1'b0, 0, 1'b0, "after_backpressure");
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0
            || c_out !== 1'b0 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b sum=%h c_out=%b ovf=%b expected 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, c_out, ovf);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_input_change();
        run_op(16'h1111, 16'h1111, 1'b0, 2, 1'b1, "input_change");
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 30; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), "random");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_input_change();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
`default_nettype wire
